pmod_da4_spi_rx: RTL
====================

PMOD_DA4_SPI_RX -- requirements
Module: pmod_da4_spi_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter DATA_W, 14, DAC data field width carried on m_axis_tdata.
REQ-003 Parameter NUM_CH, 8, number of mirrored DAC channel registers.
REQ-004 clk  in  1  50 MHz system clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sck  in  1  SPI clock from the DAC-side master; asynchronous to clk; period at least 8 clk.
REQ-007 sdi  in  1  SPI data, MSB first, sampled on the sck falling edge.
REQ-008 sync_n  in  1  active-low frame enable.
REQ-009 m_axis_tdata  out  DATA_W  received data field, frame bits [19:6].
REQ-010 m_axis_tuser  out  8  {command[3:0], address[3:0]}, frame bits [27:20].
REQ-011 m_axis_tvalid  out  1  frame available.
REQ-012 m_axis_tready  in  1  downstream accept.
REQ-013 rd_addr  in  3  mirror register select.
REQ-014 rd_data  out  DATA_W  mirror register contents at rd_addr; combinational.
REQ-015 frame_err  out  1  one-cycle pulse on a short frame.
REQ-016 overflow  out  1  one-cycle pulse when a complete frame is dropped.
REQ-017 frame_count  out  16  count of accepted complete frames; wraps 0xFFFF->0x0000.

Function
REQ-018 sck, sdi and sync_n SHALL each pass through a 2-flop synchronizer; sck falling edge is detected from the registered synchronized value.
REQ-019 The FSM SHALL have states IDLE, SHIFT and WAIT_HIGH.
REQ-020 IDLE->SHIFT on synchronized sync_n low; the bit counter clears to 0.
REQ-021 In SHIFT each detected sck falling edge SHALL shift the synchronized sdi into a 32-bit register LSB-side and increment the bit counter.
REQ-022 On the 32nd falling edge the frame SHALL complete and the FSM SHALL enter WAIT_HIGH; further edges are ignored until sync_n goes high.
REQ-023 sync_n high in SHIFT with fewer than 32 bits SHALL pulse frame_err, discard the frame and return to IDLE.
REQ-024 WAIT_HIGH->IDLE on synchronized sync_n high.
REQ-025 On a completed frame, m_axis_tvalid SHALL assert on the cycle after completion and hold tdata/tuser until a cycle with tvalid&tready.
REQ-026 A frame completing while tvalid=1 and tready=0 SHALL pulse overflow and be dropped; held data is unchanged, the mirror is still updated and frame_count is not incremented.
REQ-027 Completion on the same cycle as a tvalid&tready handshake SHALL load the new frame, with no overflow.
REQ-028 frame_count SHALL increment once per frame loaded into the output register.
REQ-029 For command 0011 the mirror SHALL be updated: address 0-7 writes that channel; address 1111 writes all channels; other addresses are ignored.
REQ-030 Other commands SHALL pass to the stream only and SHALL NOT change the mirror.

Reset
REQ-031 While rst_n=0, and asynchronously on assertion, the block SHALL set: FSM to IDLE; synchronizers to idle levels (sck 1, sync_n 1, sdi 0); m_axis_tvalid, frame_err and overflow to 0; tdata, tuser, frame_count and all mirror registers to 0.
REQ-032 Reset released mid-frame SHALL start in IDLE; a frame already in progress is ignored until sync_n is seen high and then low again.

Structure
REQ-033 Command codes, the all-channel address (4'hF), the frame length (32) and the field bit positions SHALL live in shared include pmod_da4_defs.vh, also used by pmod_da4.
REQ-034 One sub-module, sync_edge, SHALL provide the 2-flop synchronizer plus falling-edge detect; it is instantiated for sck, and its synchronizer alone for sdi and sync_n.

Verification
REQ-035 Frame 0x03_2A_BC_C0 (cmd 3, addr 2, data 0x2AF3) with tready=1 -> tvalid pulse, tdata=0x2AF3, tuser=0x32; rd_addr=2 gives 0x2AF3; frame_count=1.
REQ-036 Frame cmd 3, addr F, data 0x1555 -> all 8 mirror registers read 0x1555.
REQ-037 sync_n raised after 20 bits -> frame_err pulses once; tvalid stays 0; mirror and frame_count unchanged.
REQ-038 tready=0 with two frames sent (data 0x0100 then 0x0200) -> overflow pulses once; tdata holds 0x0100 until tready; mirror holds 0x0200.
REQ-039 rst_n asserted after bit 15 and released -> all outputs 0; the next full frame is received correctly.
REQ-040 65536 accepted frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/pmod_da4_spi_rx_pkg.sv
// Shared frame definitions for the PMOD DA4 SPI receiver (also used by the
// pmod_da4 transmitter side): command codes, broadcast address, frame length,
// field bit positions and the receiver FSM state type.
package pmod_da4_spi_rx_pkg;

  localparam int FRAME_LEN = 32;

  localparam int CMD_MSB  = 27;
  localparam int CMD_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 20;
  localparam int DATA_MSB = 19;
  localparam int DATA_LSB = 6;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_ALL         = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/pmod_da4_spi_rx_sync_edge.sv
// sync_edge: 2-flop synchronizer with optional falling-edge detect taken from
// the registered synchronized value.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized level
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition (0 when EDGE_EN=0)
module sync_edge #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= sync_q[1];
      end
      assign fall_o = prev_q & ~sync_q[1];
    end else begin : g_no_edge
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pmod_da4_spi_rx.sv
// pmod_da4_spi_rx: SPI slave receiving 32-bit DA4 command frames. Each
// complete frame is offered on an AXI-stream style output and, for the
// write-and-update command, mirrored into per-channel registers.
// Ports:
//   clk, rst_n              : system clock, async active-low reset
//   sck, sdi, sync_n        : SPI from the DAC-side master (async to clk)
//   m_axis_tdata/tuser      : data field / {command, address} of held frame
//   m_axis_tvalid/tready    : stream handshake
//   rd_addr, rd_data        : combinational mirror register read
//   frame_err, overflow     : one-cycle pulses (short frame / dropped frame)
//   frame_count             : frames loaded into the output register
module pmod_da4_spi_rx
  import pmod_da4_spi_rx_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int NUM_CH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              sdi,
  input  logic              sync_n,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [7:0]        m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_err,
  output logic              overflow,
  output logic [15:0]       frame_count
);

  localparam int CH_W = $clog2(NUM_CH);

  logic sck_fall, sdi_s, sync_n_s;
  logic sck_lvl_unused, sdi_fall_unused, sync_n_fall_unused;

  sync_edge #(.RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sck (
    .clk(clk), .rst_n(rst_n), .d_i(sck), .q_o(sck_lvl_unused), .fall_o(sck_fall)
  );
  sync_edge #(.RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sdi (
    .clk(clk), .rst_n(rst_n), .d_i(sdi), .q_o(sdi_s), .fall_o(sdi_fall_unused)
  );
  sync_edge #(.RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_n (
    .clk(clk), .rst_n(rst_n), .d_i(sync_n), .q_o(sync_n_s), .fall_o(sync_n_fall_unused)
  );

  state_e                state_q;
  logic [5:0]            bit_cnt_q;
  // Only 31 bits are stored: the 32nd bit goes straight from sdi into the frame.
  logic [FRAME_LEN-2:0]  shreg_q;
  // warm_q marks when the synchronizers hold real samples rather than reset
  // levels; armed_q then requires sync_n to be seen high before a frame can
  // start, so a frame already in progress at reset release is ignored.
  logic [1:0]            warm_q;
  logic                  armed_q;
  logic                  tvalid_q, frame_err_q, overflow_q;
  logic [DATA_W-1:0]     tdata_q;
  logic [7:0]            tuser_q;
  logic [15:0]           frame_count_q;
  logic [DATA_W-1:0]     mirror_q [NUM_CH];

  logic [FRAME_LEN-1:0]  frame_w;
  logic [3:0]            cmd_w, addr_w;
  logic [DATA_W-1:0]     data_w;
  logic [9:0]            frame_rsvd_unused;
  logic                  frame_done, load;

  assign frame_w = {shreg_q, sdi_s};
  assign cmd_w   = frame_w[CMD_MSB:CMD_LSB];
  assign addr_w  = frame_w[ADDR_MSB:ADDR_LSB];
  assign data_w  = frame_w[DATA_MSB:DATA_LSB];
  assign frame_rsvd_unused = {frame_w[FRAME_LEN-1:CMD_MSB+1], frame_w[DATA_LSB-1:0]};

  assign frame_done = (state_q == ST_SHIFT) && !sync_n_s && sck_fall &&
                      (bit_cnt_q == 6'(FRAME_LEN - 1));
  // A frame completing on a handshake cycle replaces the outgoing one.
  assign load = frame_done && (!tvalid_q || m_axis_tready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      warm_q        <= '0;
      armed_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      tdata_q       <= '0;
      tuser_q       <= '0;
      frame_count_q <= '0;
      for (int i = 0; i < NUM_CH; i++) mirror_q[i] <= '0;
    end else begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      warm_q      <= {warm_q[0], 1'b1};
      if (warm_q[1] && sync_n_s) armed_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (armed_q && !sync_n_s) begin
            state_q   <= ST_SHIFT;
            bit_cnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (sync_n_s) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (sck_fall) begin
            shreg_q   <= frame_w[FRAME_LEN-2:0];
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'(FRAME_LEN - 1)) state_q <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (sync_n_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;

      if (frame_done) begin
        if (load) begin
          tvalid_q      <= 1'b1;
          tdata_q       <= data_w;
          tuser_q       <= {cmd_w, addr_w};
          frame_count_q <= frame_count_q + 16'd1;
        end else begin
          overflow_q <= 1'b1;
        end
        // The mirror tracks the DAC even when the stream drops the frame.
        if (cmd_w == CMD_WRITE_UPDATE) begin
          if (addr_w == ADDR_ALL) begin
            for (int i = 0; i < NUM_CH; i++) mirror_q[i] <= data_w;
          end else if (int'(addr_w) < NUM_CH) begin
            mirror_q[addr_w[CH_W-1:0]] <= data_w;
          end
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign frame_count   = frame_count_q;
  assign rd_data       = mirror_q[rd_addr];

endmodule
